// File: rtl/adc_window_averager.sv
// Windowed mean/min/max of ADC samples captured on the falling edge of the driver's busy flag.
// Non-overlapping windows of 2^LOG2N samples; results are published with a one-cycle valid strobe.
module adc_window_averager #(
    parameter int BITS  = 16,
    parameter int LOG2N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busy,
    input  logic [BITS-1:0] data,
    input  logic            clr,
    output logic [BITS-1:0] avg,
    output logic [BITS-1:0] vmin,
    output logic [BITS-1:0] vmax,
    output logic            valid,
    output logic [LOG2N:0]  fill
);

    localparam int ACC_W = BITS + LOG2N;
    localparam logic [LOG2N:0] LAST = (LOG2N+1)'((1 << LOG2N) - 1);
    localparam logic [LOG2N:0] ONE  = (LOG2N+1)'(1);

    function automatic logic [BITS-1:0] umin(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [BITS-1:0] umax(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Divide by the window length with plain truncation; the sum cannot exceed ACC_W bits.
    function automatic logic [BITS-1:0] mean_trunc(input logic [ACC_W-1:0] a);
        return a[ACC_W-1 -: BITS];
    endfunction

    logic             busy_q;
    logic [LOG2N:0]   cnt;
    logic [ACC_W-1:0] acc;
    logic [BITS-1:0]  mn;
    logic [BITS-1:0]  mx;

    logic             strobe;
    logic             first;
    logic             closing;
    logic [ACC_W-1:0] acc_nxt;
    logic [BITS-1:0]  mn_nxt;
    logic [BITS-1:0]  mx_nxt;

    // Stage 0: edge detect and next window state, all combinational from the current sample
    always_comb begin
        strobe  = busy_q & ~busy;
        first   = (cnt == '0);
        closing = (cnt == LAST);
        acc_nxt = first ? ACC_W'(data) : acc + ACC_W'(data);
        mn_nxt  = first ? data : umin(mn, data);
        mx_nxt  = first ? data : umax(mx, data);
    end

    // Stage 1: window registers and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mn     <= '0;
            mx     <= '0;
            avg    <= '0;
            vmin   <= '0;
            vmax   <= '0;
            valid  <= 1'b0;
        end else begin
            busy_q <= busy;
            valid  <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (strobe) begin
                acc <= acc_nxt;
                mn  <= mn_nxt;
                mx  <= mx_nxt;
                if (closing) begin
                    avg   <= mean_trunc(acc_nxt);
                    vmin  <= mn_nxt;
                    vmax  <= mx_nxt;
                    valid <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

    assign fill = cnt;

endmodule

// File: tb/tb_adc_window_averager.sv
// Scoreboard bench for adc_window_averager: a N=4 instance and a pass-through (N=1) instance
// share the same busy/data/clr stimulus and are checked against a queue-based window model.
module tb_adc_window_averager;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy = 1'b0;
    logic [15:0] data = '0;
    logic        clr = 1'b0;

    logic [15:0] avg4, vmin4, vmax4;
    logic        valid4;
    logic [2:0]  fill4;
    logic [15:0] avg1, vmin1, vmax1;
    logic        valid1;
    logic [0:0]  fill1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] mn;
        logic [15:0] mx;
        int          at;
    } exp_t;

    exp_t exp4[$];
    exp_t exp1[$];
    int   win4[$];
    int   win1[$];
    exp_t last4;
    exp_t last1;

    adc_window_averager #(.BITS(16), .LOG2N(2)) dut4 (
        .clk(clk), .rst(rst), .busy(busy), .data(data), .clr(clr),
        .avg(avg4), .vmin(vmin4), .vmax(vmax4), .valid(valid4), .fill(fill4)
    );

    adc_window_averager #(.BITS(16), .LOG2N(0)) dut1 (
        .clk(clk), .rst(rst), .busy(busy), .data(data), .clr(clr),
        .avg(avg1), .vmin(vmin1), .vmax(vmax1), .valid(valid1), .fill(fill1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: a window is a list of samples; when it holds n samples it yields mean/min/max.
    function automatic exp_t close_window(input int w[$], input int at);
        exp_t e;
        int sum = 0;
        int lo = w[0];
        int hi = w[0];
        foreach (w[i]) begin
            sum += w[i];
            if (w[i] < lo) lo = w[i];
            if (w[i] > hi) hi = w[i];
        end
        e.a  = 16'(sum / w.size());
        e.mn = 16'(lo);
        e.mx = 16'(hi);
        e.at = at;
        return e;
    endfunction

    task automatic model_accept(input int s, input int at);
        win4.push_back(s);
        win1.push_back(s);
        if (win4.size() == 4) begin
            last4 = close_window(win4, at);
            exp4.push_back(last4);
            win4.delete();
        end
        if (win1.size() == 1) begin
            last1 = close_window(win1, at);
            exp1.push_back(last1);
            win1.delete();
        end
    endtask

    task automatic model_clear();
        win4.delete();
        win1.delete();
    endtask

    task automatic model_reset();
        model_clear();
        last4 = '{a: 16'd0, mn: 16'd0, mx: 16'd0, at: 0};
        last1 = '{a: 16'd0, mn: 16'd0, mx: 16'd0, at: 0};
    endtask

    task automatic check_state(input string tag);
        check({tag, "_fill4"}, int'(fill4), win4.size());
        check({tag, "_fill1"}, int'(fill1), win1.size());
        check({tag, "_avg4"},  int'(avg4),  int'(last4.a));
        check({tag, "_vmin4"}, int'(vmin4), int'(last4.mn));
        check({tag, "_vmax4"}, int'(vmax4), int'(last4.mx));
        check({tag, "_avg1"},  int'(avg1),  int'(last1.a));
    endtask

    // One 10-cycle busy pulse, then 10 cycles low; the sample sits on data while busy is low.
    task automatic send(input logic [15:0] s, input bit with_clr);
        @(posedge clk); #1;
        busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        busy = 1'b0;
        data = s;
        clr  = with_clr;
        if (with_clr) model_clear();
        else model_accept(int'(s), cyc + 1);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_state("after_sample");
        repeat (8) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        model_clear();
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check_state("after_clr");
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_state("after_rst");
        check("after_rst_valid4", int'(valid4), 0);
    endtask

    task automatic check_monitor(input string tag, input logic [15:0] a, input logic [15:0] mn,
                                 input logic [15:0] mx, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            check({tag, "_unexpected_valid"}, 1, 0);
        end else begin
            e = q.pop_front();
            check({tag, "_valid_cycle"}, cyc, e.at);
            check({tag, "_avg"},  int'(a),  int'(e.a));
            check({tag, "_vmin"}, int'(mn), int'(e.mn));
            check({tag, "_vmax"}, int'(mx), int'(e.mx));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid4) check_monitor("w4", avg4, vmin4, vmax4, exp4);
        if (!rst && valid1) check_monitor("w1", avg1, vmin1, vmax1, exp1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");
        check("reset_valid4", int'(valid4), 0);
        check("reset_valid1", int'(valid1), 0);

        // Basic window
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b0);
        send(16'd400, 1'b0);
        check("basic_avg_const", int'(avg4), 250);
        check("basic_vmin_const", int'(vmin4), 100);
        check("basic_vmax_const", int'(vmax4), 400);

        // Truncation and full scale
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        check("trunc_avg_const", int'(avg4), 1);
        repeat (4) send(16'hFFFF, 1'b0);
        check("fullscale_avg_const", int'(avg4), 32'hFFFF);

        // Clear mid-window, and clear colliding with a strobe
        send(16'd5, 1'b0);
        send(16'd7, 1'b0);
        pulse_clr();
        repeat (4) send(16'd8, 1'b0);
        send(16'd99, 1'b1);
        check("clr_strobe_fill_const", int'(fill4), 0);

        // Reset mid-window; busy stays low across release
        send(16'd11, 1'b0);
        send(16'd12, 1'b0);
        send(16'd13, 1'b0);
        pulse_rst();
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_state("busy_low_after_rst");
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b0);
        send(16'd40, 1'b0);
        check("post_rst_avg_const", int'(avg4), 25);

        // Continuous run
        for (int i = 0; i < 12; i++) send(16'(i), 1'b0);

        // Pass-through samples (also land in the N=4 window)
        send(16'h1234, 1'b0);
        send(16'h0001, 1'b0);
        check("pass_avg1_const", int'(avg1), 32'h0001);
        pulse_clr();

        // Randomised run
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 5))
                0: s = 16'h0000;
                1: s = 16'hFFFF;
                default: s = 16'($urandom);
            endcase
            if ($urandom_range(0, 14) == 0) pulse_clr();
            send(s, $urandom_range(0, 9) == 0);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pending_w4", exp4.size(), 0);
        check("pending_w1", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_window_averager.md
# adc_window_averager

Downstream consumer of the ADS8865 serial ADC driver. It detects the end of each conversion/readout (falling edge of the driver's `busy`) and captures the 16-bit straight-binary sample. It accumulates non-overlapping windows of 2^LOG2N samples. At each window close it publishes the window mean, minimum and maximum with a one-cycle `valid` strobe, for use by display and logging stages.

## Interface
- `BITS`, 16: sample width; must match the driver's `BITS`.
- `LOG2N`, 4: log2 of window length; legal range 0..8. With 0, every sample passes straight through.
- `clk` input 1: system clock; the same clock that drives the ADC driver.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `busy` input 1: driver busy flag; the 1→0 transition marks a new sample.
- `data` input BITS: driver sample register. Upstream guarantees it is stable whenever `busy`=0.
- `clr` input 1: synchronous window restart; discards the partial window.
- `avg` output BITS: mean of the last completed window.
- `vmin` output BITS: minimum of the last completed window.
- `vmax` output BITS: maximum of the last completed window.
- `valid` output 1: high for exactly one cycle when `avg`, `vmin` and `vmax` are updated.
- `fill` output LOG2N+1: number of samples in the current partial window, 0..2^LOG2N−1.

## Operation
- **Edge detect.** `busy_q` is a register of `busy` and resets to 0. Define `strobe = busy_q & ~busy`.
  - A `busy` held low through reset release never produces a strobe.
  - Only a high→low transition produces a strobe.
- **Window state.** Holds counter `cnt` (= `fill`), accumulator `acc` (BITS+LOG2N bits, which cannot overflow), and running `mn`/`mx`.
- **Strobe handling.** On each strobe (with `clr`=0 and `rst`=0), let `s` = `data` sampled in the strobe cycle:
  - If `cnt`=0: `acc`←`s`, `mn`←`s`, `mx`←`s`.
  - Otherwise: `acc`←`acc`+`s`, `mn`←min(`mn`,`s`), `mx`←max(`mx`,`s`).
  - If `cnt`=2^LOG2N−1, the window closes:
    - `avg`←(`acc`+`s`)>>LOG2N, truncated with no rounding.
    - `vmin`/`vmax`←the final min/max, including `s`.
    - `valid`←1 and `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- **Holding.** `avg`/`vmin`/`vmax` hold until the next window closes. `mn`/`mx` are internal and never exposed mid-window.
- **Clear.** `clr`=1 forces `cnt`←0 and `valid`←0, and leaves `avg`/`vmin`/`vmax` unchanged.
  - `clr` together with a strobe: `clr` wins and that sample is discarded.
- **Reset.** `rst`=1, including mid-window, clears all state:
  - `avg`, `vmin`, `vmax` = 0
  - `valid` = 0, `fill` = 0
  - `busy_q` = 0, `acc`/`mn`/`mx` = 0
- **Comparisons.** Min and max compare unsigned.
- **LOG2N=0.** Every strobe closes a window: `avg`=`vmin`=`vmax`=`s`.

## Timing
- The strobe is combinational from `busy` and the registered `busy_q`.
  - The sample is taken at the rising edge that ends the first cycle in which `busy`=0 after `busy`=1.
- **Latency.** `valid` and the updated outputs appear in the cycle after the closing strobe cycle: one-clock latency from the `busy` falling-edge cycle.
- **Valid width.** `valid` is a single-cycle pulse. Back-to-back windows never merge pulses, because the driver's minimum sample period is far above 2 cycles. If strobes arrive on consecutive cycles, each is still accepted.
- **No backpressure.** The consumer must latch `avg`/`vmin`/`vmax` on `valid`, or use them any time before the next `valid`.
- **Fill.** `fill` updates in the same edge as the sample capture.

## Test plan
All scenarios use LOG2N=2 (N=4) and BITS=16, with strobes produced by 10-cycle `busy` high pulses spaced 20 cycles apart.
- **Basic window.** Samples 100, 200, 300, 400 → one `valid` pulse, one cycle after the 4th `busy` fall; `avg`=250, `vmin`=100, `vmax`=400. `fill` steps 1, 2, 3, 0.
- **Truncation / full scale.** Samples 1, 1, 1, 2 → `avg`=1. Then 4×0xFFFF → `avg`=0xFFFF, `vmin`=`vmax`=0xFFFF, with no wrap.
- **Clear.**
  - Samples 5, 7, then `clr` for 1 cycle, then 4×8 → `avg`=8, `vmin`=8, `vmax`=8, and only one `valid` pulse.
  - `clr` asserted in the same cycle as a strobe → that sample is not counted (`fill` stays 0).
- **Reset.**
  - Reset after 3 samples → all outputs 0 and `fill`=0.
  - Holding `busy`=0 across reset release produces no strobe.
  - The next 4 samples 10, 20, 30, 40 → `avg`=25.
- **Continuous run.** 12 consecutive samples 0..11 → exactly 3 `valid` pulses with `avg` = 1, 5, 9; `vmin` = 0, 4, 8; `vmax` = 3, 7, 11. `avg` holds between pulses.
- **Pass-through (LOG2N=0).** Samples 0x1234, then 0x0001 → `valid` after each, with `avg`=`vmin`=`vmax` = the sample.
